crossing_reg_hs_a: RTL

Source-side crossing register with a toggle request/acknowledge handshake, and the successor to the plain enable-load crossing register.
- Captures a WIDTH-bit value and holds Q_OUT frozen while the destination domain samples it.
- Signals each new value by toggling Q_REQ.
- Accepts a toggle acknowledge from the destination and synchronises it through a configurable number of flops.
- Queues at most one newer value while a transfer is in flight.
- Sits at every multi-bit control/status crossing where a bare register is unsafe.

---
 rtl/crossing_reg_hs_a_if.sv | 15 +
 rtl/crossing_reg_hs_a.sv | 95 +++++++++
 2 files changed

// File: rtl/crossing_reg_hs_a_if.sv
// crossing_reg_hs_a_if: load, hold and toggle-handshake signals of the source-side crossing register
interface crossing_reg_hs_a_if #(
   parameter int width = 1,
   parameter int drop_w = 8
);
   logic              EN;
   logic [width-1:0]  D_IN;
   logic [width-1:0]  Q_OUT;
   logic              Q_REQ;
   logic              ACK_IN;
   logic              RDY;
   logic [drop_w-1:0] DROPS;
   modport master (output EN, D_IN, ACK_IN, input Q_OUT, Q_REQ, RDY, DROPS);
   modport slave (input EN, D_IN, ACK_IN, output Q_OUT, Q_REQ, RDY, DROPS);
endinterface

// File: rtl/crossing_reg_hs_a.sv
// crossing_reg_hs_a: source-side crossing register with toggle req/ack handshake and saturating drop count
// Define CROSSING_REG_COALESCE_EN to keep one newer value pending while a transfer is in flight.
module crossing_reg_hs_a #(
   parameter int              width = 1,
   parameter logic [width-1:0] init = '0,
   parameter int              sync_stages = 2,
   parameter int              drop_w = 8
) (
   input logic CLK,
   input logic RST,
   crossing_reg_hs_a_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t st, st_n;
   logic [width-1:0] q_n;
   logic [sync_stages-1:0] ack_q;
   logic req_n, inc, ack_s, done;
   generate
      if (sync_stages < 2 || sync_stages > 4) begin : g_bad
         $error("crossing_reg_hs_a: sync_stages must be 2..4");
      end
   endgenerate
   assign ack_s = ack_q[sync_stages-1];
   assign done = ack_s == bus.Q_REQ;
   assign bus.RDY = st == IDLE;
`ifdef CROSSING_REG_COALESCE_EN
   logic [width-1:0] pd, pd_n;
   logic pv, pv_n;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         pd <= init;
         pv <= 1'b0;
      end else begin
         pd <= pd_n;
         pv <= pv_n;
      end
`endif
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         st <= IDLE;
         ack_q <= '0;
         bus.Q_OUT <= init;
         bus.Q_REQ <= 1'b0;
         bus.DROPS <= '0;
      end else begin
         st <= st_n;
         ack_q <= {ack_q[sync_stages-2:0], bus.ACK_IN};
         bus.Q_OUT <= q_n;
         bus.Q_REQ <= req_n;
         bus.DROPS <= bus.DROPS + drop_w'(inc && !(&bus.DROPS));
      end
   // done is only meaningful in BUSY, so stray acks while IDLE are ignored
   always_comb begin
      st_n = st;
      q_n = bus.Q_OUT;
      req_n = bus.Q_REQ;
      inc = 1'b0;
`ifdef CROSSING_REG_COALESCE_EN
      pd_n = pd;
      pv_n = pv;
`endif
      if (st == IDLE) begin
         if (bus.EN) begin
            q_n = bus.D_IN;
            req_n = ~bus.Q_REQ;
            st_n = BUSY;
         end
      end else if (!done) begin
`ifdef CROSSING_REG_COALESCE_EN
         if (bus.EN) begin
            pd_n = bus.D_IN;
            pv_n = 1'b1;
            inc = pv;
         end
`else
         inc = bus.EN;
`endif
      end else if (bus.EN) begin
         q_n = bus.D_IN;
         req_n = ~bus.Q_REQ;
`ifdef CROSSING_REG_COALESCE_EN
         inc = pv;
         pv_n = 1'b0;
`endif
      end
`ifdef CROSSING_REG_COALESCE_EN
      else if (pv) begin
         q_n = pd;
         req_n = ~bus.Q_REQ;
         pv_n = 1'b0;
      end
`endif
      else st_n = IDLE;
   end
endmodule
